// File: rtl/morra_pkg.sv
// Shared codes, phase enum and result record for the MorraCinese scoreboard stage.
package morra_pkg;

    localparam int W_TALLY = 4;

    typedef enum logic [1:0] {
        M_INVALIDA = 2'b00,
        M_P1       = 2'b01,
        M_P2       = 2'b10,
        M_PAREGGIO = 2'b11
    } manche_t;

    typedef enum logic [1:0] {
        P_IN_CORSO = 2'b00,
        P_P1       = 2'b01,
        P_P2       = 2'b10,
        P_PAREGGIO = 2'b11
    } partita_t;

    typedef enum logic [1:0] {
        ATTESA = 2'b00,
        GIOCO  = 2'b01,
        FINE   = 2'b10
    } stato_t;

    // Record layout at the default tally width; the top rebuilds it at its own W.
    typedef struct packed {
        partita_t             partita;
        logic [W_TALLY-1:0]   vinte_p1;
        logic [W_TALLY-1:0]   vinte_p2;
        logic [W_TALLY-1:0]   pareggi;
    } record_t;

endpackage

// File: rtl/morra_contatore_sat.sv
// W-bit tally counter: synchronous clear, increment enable, saturates at all-ones.
module morra_contatore_sat #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/morra_tabellone.sv
// Scoreboard stage behind MorraCinese: tallies rounds, tracks phase and
// hands one result record per game to a host over valid/ready.
module morra_tabellone
    import morra_pkg::*;
#(
    parameter int W = W_TALLY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               INIZIO,
    input  logic [1:0]         MANCHE,
    input  logic [1:0]         PARTITA,
    output logic [W-1:0]       VINTE_P1,
    output logic [W-1:0]       VINTE_P2,
    output logic [W-1:0]       PAREGGI,
    output logic [W-1:0]       VALIDE,
    output logic [1:0]         STATO,
    output logic               REC_VALID,
    output logic [2+3*W-1:0]   REC_DATA,
    input  logic               REC_READY,
    output logic               OVERRUN
);

    typedef struct packed {
        partita_t     partita;
        logic [W-1:0] vinte_p1;
        logic [W-1:0] vinte_p2;
        logic [W-1:0] pareggi;
    } rec_t;

    localparam int N_CNT = 4;

    stato_t       stato_reg;
    logic         ini_d_reg;
    logic         rec_valid_reg;
    rec_t         rec_reg;
    logic         overrun_reg;

    logic         counting;
    logic         game_end;
    logic         inc       [N_CNT];
    logic [W-1:0] cnt       [N_CNT];
    logic [W-1:0] cnt_next  [N_CNT];
    rec_t         rec_next;

    // ini_d only ever follows an INIZIO edge, which always lands in GIOCO,
    // so the first-move edge of a new game is counted either way.
    assign counting = !INIZIO && ((stato_reg == GIOCO) || ini_d_reg);
    assign game_end = counting && (PARTITA != P_IN_CORSO);

    assign inc[0] = counting && (MANCHE == M_P1);
    assign inc[1] = counting && (MANCHE == M_P2);
    assign inc[2] = counting && (MANCHE == M_PAREGGIO);
    assign inc[3] = counting && (MANCHE != M_INVALIDA);

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            morra_contatore_sat #(
                .W (W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr   (INIZIO),
                .inc   (inc[gi]),
                .count (cnt[gi])
            );

            // Post-update value, so the record includes the ending round.
            assign cnt_next[gi] = (inc[gi] && (cnt[gi] != {W{1'b1}}))
                                ? cnt[gi] + 1'b1 : cnt[gi];
        end
    endgenerate

    always_comb begin
        rec_next          = '0;
        rec_next.partita  = partita_t'(PARTITA);
        rec_next.vinte_p1 = cnt_next[0];
        rec_next.vinte_p2 = cnt_next[1];
        rec_next.pareggi  = cnt_next[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stato_reg     <= ATTESA;
            ini_d_reg     <= 1'b0;
            rec_valid_reg <= 1'b0;
            rec_reg       <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            ini_d_reg <= INIZIO;

            case (stato_reg)
                ATTESA: begin
                    if (INIZIO) stato_reg <= GIOCO;
                end
                GIOCO: begin
                    if (INIZIO)        stato_reg <= GIOCO;
                    else if (game_end) stato_reg <= FINE;
                end
                FINE: begin
                    if (INIZIO) stato_reg <= GIOCO;
                end
                default: stato_reg <= ATTESA;
            endcase

            // A pending record accepted on this edge frees the slot for a new one.
            if (game_end && (!rec_valid_reg || REC_READY)) begin
                rec_reg       <= rec_next;
                rec_valid_reg <= 1'b1;
            end else begin
                if (rec_valid_reg && REC_READY) rec_valid_reg <= 1'b0;
                if (game_end)                   overrun_reg   <= 1'b1;
            end
        end
    end

    assign VINTE_P1  = cnt[0];
    assign VINTE_P2  = cnt[1];
    assign PAREGGI   = cnt[2];
    assign VALIDE    = cnt[3];
    assign STATO     = stato_reg;
    assign REC_VALID = rec_valid_reg;
    assign REC_DATA  = rec_reg;
    assign OVERRUN   = overrun_reg;

endmodule

// File: tb/tb_morra_tabellone.sv
// Bench for morra_tabellone: directed game scenarios plus random play,
// every edge checked against a round/game-level reference model.
module tb_morra_tabellone;

    localparam int W    = 4;
    localparam int MAXC = (1 << W) - 1;

    logic             clk;
    logic             rst;
    logic             INIZIO;
    logic [1:0]       MANCHE;
    logic [1:0]       PARTITA;
    logic [W-1:0]     VINTE_P1;
    logic [W-1:0]     VINTE_P2;
    logic [W-1:0]     PAREGGI;
    logic [W-1:0]     VALIDE;
    logic [1:0]       STATO;
    logic             REC_VALID;
    logic [2+3*W-1:0] REC_DATA;
    logic             REC_READY;
    logic             OVERRUN;

    morra_tabellone #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .INIZIO    (INIZIO),
        .MANCHE    (MANCHE),
        .PARTITA   (PARTITA),
        .VINTE_P1  (VINTE_P1),
        .VINTE_P2  (VINTE_P2),
        .PAREGGI   (PAREGGI),
        .VALIDE    (VALIDE),
        .STATO     (STATO),
        .REC_VALID (REC_VALID),
        .REC_DATA  (REC_DATA),
        .REC_READY (REC_READY),
        .OVERRUN   (OVERRUN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: phase as a small int (0 idle, 1 playing, 2 over)
    int               m_phase;
    int               m_p1, m_p2, m_dr, m_val;
    bit               m_rv;
    logic [2+3*W-1:0] m_rd;
    bit               m_ovr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_p1 = 0; m_p2 = 0; m_dr = 0; m_val = 0;
        m_rv = 0; m_rd = '0; m_ovr = 0;
    endtask

    task automatic model_edge(input logic ini, input logic [1:0] m, input logic [1:0] p, input logic rdy);
        bit xfer;
        bit ended;
        bit load;
        logic [2+3*W-1:0] rec;
        xfer  = m_rv && rdy;
        ended = 0;
        load  = 0;
        rec   = '0;
        if (ini) begin
            m_p1 = 0; m_p2 = 0; m_dr = 0; m_val = 0;
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (m == 2'b01) m_p1 = sat_inc(m_p1);
            if (m == 2'b10) m_p2 = sat_inc(m_p2);
            if (m == 2'b11) m_dr = sat_inc(m_dr);
            if (m != 2'b00) m_val = sat_inc(m_val);
            if (p != 2'b00) begin
                ended = 1;
                m_phase = 2;
                rec = {p, W'(m_p1), W'(m_p2), W'(m_dr)};
            end
        end
        if (xfer)
            $display("xfer record partita=%0d p1=%0d p2=%0d dr=%0d", m_rd[3*W+1:3*W],
                     m_rd[3*W-1:2*W], m_rd[2*W-1:W], m_rd[W-1:0]);
        if (ended) begin
            if (!m_rv || rdy) load = 1;
            else m_ovr = 1;
        end
        if (load) begin
            m_rv = 1;
            m_rd = rec;
        end else if (xfer) begin
            m_rv = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".p1"},  32'(VINTE_P1),  32'(m_p1));
        check_val({tag, ".p2"},  32'(VINTE_P2),  32'(m_p2));
        check_val({tag, ".dr"},  32'(PAREGGI),   32'(m_dr));
        check_val({tag, ".val"}, 32'(VALIDE),    32'(m_val));
        check_val({tag, ".st"},  32'(STATO),     32'(m_phase));
        check_val({tag, ".rv"},  32'(REC_VALID), 32'(m_rv));
        check_val({tag, ".rd"},  32'(REC_DATA),  32'(m_rd));
        check_val({tag, ".ovr"}, 32'(OVERRUN),   32'(m_ovr));
    endtask

    // Drive one edge's inputs, advance the model on that edge, check 1ns after.
    task automatic step(input string tag, input logic ini, input logic [1:0] m,
                        input logic [1:0] p, input logic rdy);
        INIZIO = ini; MANCHE = m; PARTITA = p; REC_READY = rdy;
        @(posedge clk);
        model_edge(ini, m, p, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; INIZIO = 0; MANCHE = 0; PARTITA = 0; REC_READY = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst0");
        rst = 1'b0;

        // Idle phase ignores round traffic
        step("idle", 0, 2'b01, 2'b01, 0);

        // Game 1 ends with P1 win, record left pending
        step("g1_ini", 1, 2'b11, 2'b10, 0);
        step("g1_m",   0, 2'b01, 2'b00, 0);
        step("g1_end", 0, 2'b01, 2'b01, 0);
        // Game 2 reaches three P1 wins, then reset mid-game with record pending
        step("g2_ini", 1, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) step("g2_m", 0, 2'b01, 2'b00, 0);
        check_val("pre_rst_p1", 32'(VINTE_P1), 32'd3);
        check_val("pre_rst_rv", 32'(REC_VALID), 32'd1);
        async_reset("midrst");

        // Mixed round sequence
        step("seq_ini", 1, 2'b00, 2'b00, 0);
        step("seq", 0, 2'b01, 2'b00, 0);
        step("seq", 0, 2'b01, 2'b00, 0);
        step("seq", 0, 2'b10, 2'b00, 0);
        step("seq", 0, 2'b11, 2'b00, 0);
        step("seq", 0, 2'b00, 2'b00, 0);
        check_val("seq_p1", 32'(VINTE_P1), 32'd2);
        check_val("seq_val", 32'(VALIDE), 32'd4);

        // End with P1 win, hold record for 5 cycles, counters frozen in FINE
        step("end", 0, 2'b01, 2'b01, 0);
        check_val("end_rd", 32'(REC_DATA), 32'({2'b01, 4'd3, 4'd1, 4'd1}));
        for (int i = 0; i < 5; i++) step("hold", 0, 2'b10, 2'b10, 0);
        step("take", 0, 2'b00, 2'b00, 1);

        // Saturation
        step("sat_ini", 1, 2'b00, 2'b00, 0);
        for (int i = 0; i < 20; i++) step("sat", 0, 2'b01, 2'b00, 0);
        check_val("sat_p1", 32'(VINTE_P1), 32'(MAXC));
        check_val("sat_val", 32'(VALIDE), 32'(MAXC));
        step("sat_end", 0, 2'b11, 2'b11, 0);

        // Second game ends while that record is pending -> overrun
        step("ov_ini", 1, 2'b00, 2'b00, 0);
        step("ov_m",   0, 2'b10, 2'b00, 0);
        step("ov_end", 0, 2'b10, 2'b10, 0);
        check_val("ov_flag", 32'(OVERRUN), 32'd1);
        async_reset("clr_ov");

        // Pending record accepted on the same edge a new game ends
        step("bb_ini", 1, 2'b00, 2'b00, 0);
        step("bb_e1",  0, 2'b01, 2'b01, 0);
        step("bb_ini2", 1, 2'b00, 2'b00, 0);
        step("bb_m",   0, 2'b10, 2'b00, 0);
        step("bb_e2",  0, 2'b10, 2'b10, 1);
        check_val("bb_part", 32'(REC_DATA[3*W+1:3*W]), 32'd2);
        check_val("bb_ovr", 32'(OVERRUN), 32'd0);
        step("bb_take", 0, 2'b00, 2'b00, 1);

        // INIZIO beats a game end on the same edge
        step("ip_ini", 1, 2'b00, 2'b00, 0);
        step("ip_m",   0, 2'b01, 2'b00, 0);
        step("ip_both", 1, 2'b11, 2'b11, 0);
        check_val("ip_rv", 32'(REC_VALID), 32'd0);
        step("ip_next", 0, 2'b11, 2'b00, 0);

        // Random play
        for (int n = 0; n < 800; n++) begin
            logic ini;
            logic [1:0] m;
            logic [1:0] p;
            logic rdy;
            ini = ($urandom_range(0, 11) == 0);
            m   = 2'($urandom_range(0, 3));
            p   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rdy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            else step("rnd", ini, m, p, rdy);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/morra_tabellone.md
Name: morra_tabellone

Overview:
- Downstream scoreboard stage for the rock-paper-scissors game FSMD (MorraCinese). Consumes its registered MANCHE/PARTITA outputs every clock.
- Tallies per-game round results and tracks the game phase.
- At game end, emits one result record to a host/display consumer over a valid/ready handshake.

Parameters:
- W, 4, width of every tally counter (win/draw/valid-round counts); all tally counters saturate at 2^W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- INIZIO  in  1  same signal driven into MorraCinese (new-game strobe)
- MANCHE  in  2  round result from MorraCinese: 00 invalid, 01 P1 wins, 10 P2 wins, 11 draw
- PARTITA  in  2  game result from MorraCinese: 00 in progress, 01 P1, 10 P2, 11 draw
- VINTE_P1  out  W  rounds won by player 1, current game
- VINTE_P2  out  W  rounds won by player 2, current game
- PAREGGI  out  W  drawn rounds, current game
- VALIDE  out  W  valid rounds (MANCHE != 00), current game
- STATO  out  2  phase: 00 ATTESA, 01 GIOCO, 10 FINE
- REC_VALID  out  1  result record available
- REC_DATA  out  2+3W  record {PARTITA, VINTE_P1, VINTE_P2, PAREGGI}
- REC_READY  in  1  consumer accepts record
- OVERRUN  out  1  sticky: a game ended while the previous record was still pending

Behaviour:
- Reset (async, any time, including mid-game or mid-handshake):
  - all counters = 0; STATO = ATTESA; REC_VALID = 0; REC_DATA = 0; OVERRUN = 0.
  - Internal ini_d = 0.
- Alignment: MorraCinese outputs lag its inputs by one cycle.
  - ini_d is INIZIO registered.
  - On an edge where INIZIO=1, MANCHE/PARTITA belong to the previous game and are discarded.
  - On that edge: counters cleared to 0; STATO -> GIOCO; OVERRUN and a pending record are untouched.
- Counting, on each edge with STATO=GIOCO and INIZIO=0 (this includes the ini_d=1 edge, which carries the first move of the new game):
  - MANCHE=01: VINTE_P1+1
  - MANCHE=10: VINTE_P2+1
  - MANCHE=11: PAREGGI+1
  - Any MANCHE != 00: VALIDE+1
  - MANCHE=00: no change.
  - All counters saturate at 2^W-1; there is no wrap-around.
- Game end: on a GIOCO counting edge with PARTITA != 00:
  - Counters include that edge's MANCHE.
  - STATO -> FINE.
  - Record loaded with PARTITA and the post-update counts, all sampled in that same cycle.
- FINE:
  - Counters frozen; MANCHE/PARTITA ignored.
  - Leave FINE only by INIZIO=1 (-> GIOCO, counters cleared).
- ATTESA:
  - MANCHE/PARTITA ignored.
  - INIZIO=1 -> GIOCO.
- STATO transition summary:
  - ATTESA -INIZIO-> GIOCO
  - GIOCO -PARTITA!=00-> FINE
  - GIOCO -INIZIO-> GIOCO (restart, counters cleared)
  - FINE -INIZIO-> GIOCO
- Record handshake:
  - Transfer occurs on an edge with REC_VALID & REC_READY.
  - REC_DATA is stable while REC_VALID=1 and REC_READY=0.
  - After transfer, REC_VALID drops next cycle unless a new record is loaded on that same edge.
  - New record loaded while REC_VALID=1:
    - with REC_READY=1 on that edge: old record transfers, new one loaded, REC_VALID stays 1, no overrun.
    - with REC_READY=0: old record kept, new record dropped, OVERRUN set (sticky until rst).
- INIZIO while STATO=GIOCO with PARTITA != 00 on the same edge: INIZIO wins; no record, counters cleared.
- Latency:
  - counters/STATO update 1 cycle after the MorraCinese output changes.
  - REC_VALID rises on the edge that detects PARTITA != 00.

Decomposition:
- Package morra_pkg holds:
  - MANCHE codes: M_INVALIDA, M_P1, M_P2, M_PAREGGIO
  - PARTITA codes: P_IN_CORSO, P_P1, P_P2, P_PAREGGIO
  - STATO enum: ATTESA, GIOCO, FINE
  - record struct typedef, parameterised by W
- Sub-module morra_contatore_sat: W-bit counter with clear, increment enable, saturation, async reset. Instantiated four times.

Test Plan:
- rst mid-game with VINTE_P1=3 and REC_VALID=1 -> all outputs 0 and STATO=00 immediately, before the next edge.
- INIZIO=1 edge, then MANCHE sequence 01,01,10,11,00 with PARTITA=00 -> VINTE_P1=2, VINTE_P2=1, PAREGGI=1, VALIDE=4, STATO=01.
- During a game: PARTITA=01 with MANCHE=01 -> same edge: STATO=10, REC_VALID=1, REC_DATA={01, VINTE_P1+1, VINTE_P2, PAREGGI}; while REC_READY=0 for 5 cycles, REC_DATA is held; further MANCHE=10 does not change counters.
- Saturation: W=4, 20 consecutive MANCHE=01 -> VINTE_P1=15 and VALIDE=15 (no wrap).
- Record pending (REC_READY=0), new game ends with PARTITA=10 -> OVERRUN=1, REC_DATA unchanged.
- Repeat with REC_READY=1 on the end edge -> old record transfers, new record with PARTITA=10 presented, OVERRUN=0.
- INIZIO=1 on the same edge as PARTITA=11 -> no record, counters 0, STATO=01; the following edge counts MANCHE normally.
